// File: rtl/gf_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^254 using one shared field multiply per clock.
// A division by zero gives q = 0 with div_by_zero_o set, and takes the same 14-cycle latency.
module gf_div_seq #(
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] q_o,
  output logic       div_by_zero_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [7:0] t_r;
  logic [3:0] step_r;
  logic [7:0] mul_x_s;
  logic [7:0] mul_y_s;
  logic [7:0] mul_s;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xs;
    p  = 8'h00;
    xs = x;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (xs & {8{y[i]}});
      xs = xs[7] ? ({xs[6:0], 1'b0} ^ POLY[7:0]) : {xs[6:0], 1'b0};
    end
    return p;
  endfunction

  assign in_ready_o = (state_r == ST_IDLE);

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_x_s = t_r;
    mul_y_s = t_r;
    if (state_r == ST_RUN) begin
      if (step_r == 4'd13) begin
        mul_x_s = a_r;
        mul_y_s = t_r;
      end else if ((step_r < 4'd12) && step_r[0]) begin
        mul_x_s = t_r;
        mul_y_s = b_r;
      end else begin
        mul_x_s = t_r;
        mul_y_s = t_r;
      end
    end else begin
      mul_x_s = t_r;
      mul_y_s = t_r;
    end
  end

  assign mul_s = gf_mul(mul_x_s, mul_y_s);

  // Control FSM, exponentiation datapath and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_IDLE;
      a_r           <= 8'h00;
      b_r           <= 8'h00;
      t_r           <= 8'h00;
      step_r        <= 4'd0;
      q_o           <= 8'h00;
      div_by_zero_o <= 1'b0;
      out_valid_o   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_r     <= a_i;
            b_r     <= b_i;
            t_r     <= b_i;
            step_r  <= 4'd0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          // b^127 after step 11, squared to b^254 at step 12, applied to a at step 13.
          if (step_r == 4'd13) begin
            q_o           <= mul_s;
            div_by_zero_o <= (b_r == 8'h00);
            out_valid_o   <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            t_r    <= mul_s;
            step_r <= step_r + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_div_seq.sv
// Scoreboard bench for gf_div_seq: expected quotients come from log/antilog tables
// built from generator 2, independent of the square-and-multiply datapath.
module tb_gf_div_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       dbz;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic       dbz;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;
  int   exp_tbl[0:254];
  int   log_tbl[0:255];

  gf_div_seq #(.POLY(9'h11D)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_i          (a_i),
    .b_i          (b_i),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .q_o          (q),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] model_div(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_tbl[(log_tbl[a] + 255 - log_tbl[b]) % 255]);
  endfunction

  // Consumer readiness: 0 = always ready, 1 = random stalls, 2 = held off.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on rise, hold while stalled, pop-and-compare on transfer.
  initial begin
    logic       prev_valid;
    logic       prev_xfer;
    logic [7:0] prev_q;
    logic       prev_dbz;
    exp_t       e;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_q     = 8'h00;
    prev_dbz   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (out_valid && !prev_valid && sb.size() > 0)
          chk("latency", cyc - sb[0].acc, 14);
        if (out_valid && prev_valid && !prev_xfer) begin
          chk("q_hold", q, prev_q);
          chk("dbz_hold", dbz, prev_dbz);
        end
        prev_xfer = out_valid && out_ready;
        if (prev_xfer) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got q=0x%0h with no operation outstanding", q);
          end else begin
            e = sb.pop_front();
            chk($sformatf("q a=%02h b=%02h", e.a, e.b), q, e.q);
            chk($sformatf("dbz a=%02h b=%02h", e.a, e.b), dbz, e.dbz);
          end
        end
        prev_valid = out_valid;
        prev_q     = q;
        prev_dbz   = dbz;
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic ed);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{a, b, eq, ed, cyc + 1});
        ok = 1'b1;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_i = 8'($urandom);
    b_i = 8'($urandom);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
    end
  endtask

  initial begin
    int  x;
    int  n;
    logic [7:0] ra;
    logic [7:0] rb;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_tbl[i] = x;
      log_tbl[x] = i;
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    log_tbl[0] = 0;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_i      = 8'h00;
    b_i      = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 8'h00);
    chk("rst_dbz", dbz, 0);

    // Directed vectors with hand-derived quotients.
    do_op(8'h01, 8'h02, 8'h8E, 1'b0);
    do_op(8'h02, 8'h02, 8'h01, 1'b0);
    do_op(8'h04, 8'h02, 8'h02, 1'b0);
    do_op(8'h00, 8'h37, 8'h00, 1'b0);
    do_op(8'h5A, 8'h00, 8'h00, 1'b1);
    drain(100);

    // Backpressure: consumer held off, operands toggling.
    rdy_mode = 2;
    do_op(8'hC3, 8'h1D, model_div(8'hC3, 8'h1D), 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      a_i = 8'($urandom);
      b_i = 8'($urandom);
    end
    rdy_mode = 0;
    n = 0;
    while (!(out_valid && out_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);

    // Reset in the middle of RUN, at step 7.
    do_op(8'h33, 8'h77, model_div(8'h33, 8'h77), 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_q", q, 8'h00);
    chk("midrst_dbz", dbz, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_output", out_valid, 0);
    end
    do_op(8'h33, 8'h77, model_div(8'h33, 8'h77), 1'b0);
    drain(100);

    // Random operands back-to-back with consumer stalls, boundary divisors mixed in.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      case (i % 10)
        0: rb = 8'h00;
        1: rb = 8'h01;
        2: rb = 8'hFF;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      if (i % 17 == 0) ra = 8'h00;
      do_op(ra, rb, model_div(ra, rb), rb == 8'h00);
    end
    drain(200);
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
